// File: rtl/l1_mem_pkg.sv
// Shared types for the L1 main-memory controller: source indices,
// read FSM states, the write-back holding entry and the forward lookup.
package l1_mem_pkg;

  localparam int WB_ADDR_W = 9;
  localparam int WB_DATA_W = 32;
  localparam int NUM_SRC   = 4;
  localparam int NUM_CORES = 2;

  localparam int SRC_C0_CPU = 0;
  localparam int SRC_C0_BUS = 1;
  localparam int SRC_C1_CPU = 2;
  localparam int SRC_C1_BUS = 3;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_WAIT_GNT,
    RD_ACCESS,
    RD_DONE
  } rd_state_t;

  typedef struct packed {
    logic                 valid;
    logic [WB_ADDR_W-1:0] addr;
    logic [WB_DATA_W-1:0] data;
  } wb_entry_t;

  // Search the holding registers for addr on behalf of core.
  // Returns {hit, data}. Preference: own bus, peer bus, own cpu, peer cpu.
  // Scanned lowest-preference first so the best match is written last.
  function automatic logic [WB_DATA_W:0] fwd_lookup(
    input wb_entry_t [NUM_SRC-1:0] ents,
    input logic [WB_ADDR_W-1:0]    addr,
    input logic                    core
  );
    logic [1:0] src;
    fwd_lookup = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      src = {core ^ i[0], ~i[1]};
      if (ents[src].valid && ents[src].addr == addr)
        fwd_lookup = {1'b1, ents[src].data};
    end
  endfunction

endpackage

// File: rtl/l1_mem_rd_fsm.sv
// Per-core miss-read sequencer: forward from holding registers when
// possible, otherwise wait for the memory port and count out its latency.
module l1_mem_rd_fsm
  import l1_mem_pkg::*;
#(
  parameter int ADDR_W  = WB_ADDR_W,
  parameter int DATA_W  = WB_DATA_W,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              abort,
  input  logic              req_hit,
  input  logic [DATA_W-1:0] req_hit_data,
  input  logic              live_hit,
  input  logic [DATA_W-1:0] live_hit_data,
  input  logic              gnt,
  input  logic [DATA_W-1:0] mem_data,
  output logic [ADDR_W-1:0] addr,
  output logic              want_gnt,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  rd_state_t         state;
  logic [CNT_W-1:0]  cnt;
  logic              snap_hit;
  logic [DATA_W-1:0] dq;

  // The lookup made when the request was accepted covers an entry that
  // drains on that same edge; a live match still wins as the newer data.
  assign want_gnt = (state == RD_WAIT_GNT) && !live_hit && !snap_hit;

  // Read sequencer with registered outputs; abort beats everything.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= RD_IDLE;
      cnt      <= '0;
      snap_hit <= 1'b0;
      dq       <= '0;
      addr     <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      busy     <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      if (state != RD_IDLE && abort) begin
        state <= RD_IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          RD_IDLE: if (req) begin
            state    <= RD_WAIT_GNT;
            busy     <= 1'b1;
            addr     <= req_addr;
            snap_hit <= req_hit;
            dq       <= req_hit_data;
          end
          RD_WAIT_GNT: begin
            if (live_hit) begin
              dq    <= live_hit_data;
              state <= RD_DONE;
            end else if (snap_hit) begin
              state <= RD_DONE;
            end else if (gnt) begin
              cnt   <= CNT_W'(MEM_LAT - 1);
              state <= RD_ACCESS;
            end
          end
          RD_ACCESS: begin
            if (cnt == '0) begin
              dq    <= mem_data;
              state <= RD_DONE;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          RD_DONE: begin
            rd_valid <= 1'b1;
            rd_data  <= dq;
            busy     <= 1'b0;
            state    <= RD_IDLE;
          end
          default: state <= RD_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/l1_mem_ctrl.sv
// Shared main-memory controller behind two L1 caches: per-source write-back
// holding registers, round-robin drain, per-core miss reads with forwarding.
module l1_mem_ctrl
  import l1_mem_pkg::*;
#(
  parameter int ADDR_W  = WB_ADDR_W,
  parameter int DATA_W  = WB_DATA_W,
  parameter int MEM_LAT = 2
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_SRC-1:0]                wb_valid,
  input  logic [NUM_SRC-1:0][ADDR_W-1:0]    wb_addr,
  input  logic [NUM_SRC-1:0][DATA_W-1:0]    wb_data,
  input  logic [NUM_CORES-1:0]              rd_req,
  input  logic [NUM_CORES-1:0][ADDR_W-1:0]  rd_addr,
  input  logic [NUM_CORES-1:0]              rd_abort,
  output logic [NUM_CORES-1:0][DATA_W-1:0]  rd_data,
  output logic [NUM_CORES-1:0]              rd_valid,
  output logic [NUM_CORES-1:0]              rd_busy,
  output logic                              wb_overflow
);

  wb_entry_t [NUM_SRC-1:0]             ents;
  logic [NUM_SRC-1:0]                  vld;
  logic [1:0]                          ptr;
  logic                                fair;
  logic [NUM_CORES-1:0]                want;
  logic [NUM_CORES-1:0]                gnt;
  logic                                drain;
  logic [1:0]                          dsel;
  logic [NUM_CORES-1:0][ADDR_W-1:0]    fsm_addr;
  logic [NUM_CORES-1:0][DATA_W:0]      req_lk;
  logic [NUM_CORES-1:0][DATA_W:0]      live_lk;
  logic [NUM_CORES-1:0][DATA_W-1:0]    mem_q;
  logic [DATA_W-1:0]                   mem [2**ADDR_W];

  // Valid vector and drain candidate: first valid entry at or after ptr.
  always_comb begin
    vld = '0;
    for (int i = 0; i < NUM_SRC; i++) vld[i] = ents[i].valid;
    dsel = ptr;
    for (int k = NUM_SRC - 1; k >= 0; k--)
      if (vld[ptr + 2'(k)]) dsel = ptr + 2'(k);
  end

  // Port arbitration: full buffer drains first, then reads, then drain.
  always_comb begin
    gnt   = '0;
    drain = 1'b0;
    if (&vld) begin
      drain = 1'b1;
    end else if (|want) begin
      if (want[fair]) gnt[fair]  = 1'b1;
      else            gnt[~fair] = 1'b1;
    end else if (|vld) begin
      drain = 1'b1;
    end
  end

  // Holding registers, drain pointer, read fairness and overflow flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ents        <= '0;
      ptr         <= '0;
      fair        <= 1'b0;
      wb_overflow <= 1'b0;
    end else begin
      if (|gnt) fair <= ~fair;
      if (drain) begin
        ents[dsel].valid <= 1'b0;
        ptr              <= dsel + 2'd1;
      end
      for (int i = 0; i < NUM_SRC; i++) begin
        if (wb_valid[i]) begin
          if (!ents[i].valid) ents[i] <= '{1'b1, wb_addr[i], wb_data[i]};
          else                wb_overflow <= 1'b1;
        end
      end
    end
  end

  // Single-port word memory; read data parks per core until its FSM needs it.
  always_ff @(posedge clk) begin
    if (drain) mem[ents[dsel].addr] <= ents[dsel].data;
    if (|gnt)  mem_q[gnt[1]] <= mem[fsm_addr[gnt[1]]];
  end

  for (genvar g = 0; g < NUM_CORES; g++) begin : g_core
    assign req_lk[g]  = fwd_lookup(ents, rd_addr[g], (g == 1));
    assign live_lk[g] = fwd_lookup(ents, fsm_addr[g], (g == 1));

    l1_mem_rd_fsm #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .MEM_LAT(MEM_LAT)
    ) u_rd (
      .clk          (clk),
      .reset        (reset),
      .req          (rd_req[g]),
      .req_addr     (rd_addr[g]),
      .abort        (rd_abort[g]),
      .req_hit      (req_lk[g][DATA_W]),
      .req_hit_data (req_lk[g][DATA_W-1:0]),
      .live_hit     (live_lk[g][DATA_W]),
      .live_hit_data(live_lk[g][DATA_W-1:0]),
      .gnt          (gnt[g]),
      .mem_data     (mem_q[g]),
      .addr         (fsm_addr[g]),
      .want_gnt     (want[g]),
      .rd_data      (rd_data[g]),
      .rd_valid     (rd_valid[g]),
      .busy         (rd_busy[g])
    );
  end

endmodule

// File: tb/tb_l1_mem_ctrl.sv
// Scoreboard bench for l1_mem_ctrl: directed reads push expected
// {data, due cycle}; a monitor pops and checks every rd_valid pulse.
module tb_l1_mem_ctrl;

  localparam int AW  = 9;
  localparam int DW  = 32;
  localparam int LAT = 2;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic [3:0]          wb_valid = '0;
  logic [3:0][AW-1:0]  wb_addr = '0;
  logic [3:0][DW-1:0]  wb_data = '0;
  logic [1:0]          rd_req = '0;
  logic [1:0][AW-1:0]  rd_addr = '0;
  logic [1:0]          rd_abort = '0;
  logic [1:0][DW-1:0]  rd_data;
  logic [1:0]          rd_valid;
  logic [1:0]          rd_busy;
  logic                wb_overflow;

  l1_mem_ctrl #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) dut (
    .clk        (clk),
    .reset      (reset),
    .wb_valid   (wb_valid),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .rd_req     (rd_req),
    .rd_addr    (rd_addr),
    .rd_abort   (rd_abort),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .rd_busy    (rd_busy),
    .wb_overflow(wb_overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   checks = 0;
  int   errors = 0;
  int   vcnt0 = 0;
  int   vcnt1 = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(int c, logic [DW-1:0] d, int due);
    exp_t e;
    e.data = d;
    e.due  = due;
    if (c == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic monitor();
    exp_t e;
    int   qs;
    forever begin
      @(negedge clk);
      if (!reset) begin
        for (int c = 0; c < 2; c++) begin
          if (rd_valid[c]) begin
            if (c == 0) vcnt0++; else vcnt1++;
            qs = (c == 0) ? q0.size() : q1.size();
            checks++;
            if (qs == 0) begin
              errors++;
              $display("FAIL rd%0d_unexpected: got pulse data %h at cycle %0d, expected none",
                       c, rd_data[c], cyc);
            end else begin
              if (c == 0) e = q0.pop_front(); else e = q1.pop_front();
              if (rd_data[c] !== e.data || cyc != e.due) begin
                errors++;
                $display("FAIL rd%0d_resp: got data %h cycle %0d expected data %h cycle %0d",
                         c, rd_data[c], cyc, e.data, e.due);
              end
            end
          end
        end
      end
    end
  endtask

  logic [DW-1:0] sim_data [4];
  int            v0;

  initial begin
    sim_data[0] = 32'h1111_1111;
    sim_data[1] = 32'h2222_2222;
    sim_data[2] = 32'h3333_3333;
    sim_data[3] = 32'h4444_4444;
    fork
      monitor();
    join_none

    // Reset state
    tick(3);
    chk("reset_rd_valid", rd_valid, 0);
    chk("reset_rd_busy", rd_busy, 0);
    chk("reset_overflow", wb_overflow, 0);
    chk("reset_rd_data", rd_data, 0);
    reset = 1'b0;
    tick(2);

    // Preload 0x05 through source 0 and let it drain
    wb_valid[0] = 1'b1; wb_addr[0] = 9'h05; wb_data[0] = 32'hDEAD_BEEF;
    tick(1);
    wb_valid = '0;
    tick(3);

    // Memory read, immediate grant: MEM_LAT+2 cycles
    rd_req[0] = 1'b1; rd_addr[0] = 9'h05;
    push(0, 32'hDEAD_BEEF, cyc + 1 + LAT + 2);
    tick(1);
    rd_req = '0;
    tick(7);

    // Forwarding: core1 reads 0x10 the cycle after source 1 writes it
    wb_valid[1] = 1'b1; wb_addr[1] = 9'h10; wb_data[1] = 32'h1234_5678;
    tick(1);
    wb_valid = '0;
    rd_req[1] = 1'b1; rd_addr[1] = 9'h10;
    push(1, 32'h1234_5678, cyc + 1 + 2);
    tick(1);
    rd_req = '0;
    tick(6);

    // Overflow while both reads occupy the port; fairness favours core1 now
    rd_req = 2'b11; rd_addr[0] = 9'h05; rd_addr[1] = 9'h10;
    push(1, 32'h1234_5678, cyc + 5);
    push(0, 32'hDEAD_BEEF, cyc + 6);
    tick(1);
    rd_req = '0;
    wb_valid[2] = 1'b1; wb_addr[2] = 9'h40; wb_data[2] = 32'hAAAA_0001;
    tick(1);
    wb_addr[2] = 9'h41; wb_data[2] = 32'hBBBB_0002;
    tick(1);
    wb_valid = '0;
    chk("overflow_set", wb_overflow, 1);
    tick(8);
    chk("overflow_sticky", wb_overflow, 1);

    // Abort one cycle after the request
    v0 = vcnt0;
    rd_req[0] = 1'b1; rd_addr[0] = 9'h20;
    tick(1);
    rd_req = '0;
    chk("abort_busy_high", rd_busy[0], 1);
    rd_abort[0] = 1'b1;
    tick(1);
    rd_abort = '0;
    chk("abort_busy_low", rd_busy[0], 0);
    tick(8);
    chk("abort_no_valid", vcnt0 - v0, 0);

    // First overflow entry reached memory; the dropped one did not replace it
    rd_req[0] = 1'b1; rd_addr[0] = 9'h40;
    push(0, 32'hAAAA_0001, cyc + 5);
    tick(1);
    rd_req = '0;
    tick(7);

    // All four write-backs plus both reads in one cycle
    for (int s = 0; s < 4; s++) begin
      wb_valid[s] = 1'b1;
      wb_addr[s]  = AW'(9'h50 + s);
      wb_data[s]  = sim_data[s];
    end
    rd_req = 2'b11; rd_addr[0] = 9'h05; rd_addr[1] = 9'h40;
    push(1, 32'hAAAA_0001, cyc + 6);
    push(0, 32'hDEAD_BEEF, cyc + 7);
    tick(1);
    wb_valid = '0;
    rd_req = '0;
    tick(12);
    for (int s = 0; s < 4; s++) begin
      rd_req[s % 2]  = 1'b1;
      rd_addr[s % 2] = AW'(9'h50 + s);
      push(s % 2, sim_data[s], cyc + 5);
      tick(1);
      rd_req = '0;
      tick(6);
    end

    // Reset mid-operation: pending write-back to 0x05 is lost
    wb_valid[0] = 1'b1; wb_addr[0] = 9'h05; wb_data[0] = 32'h0BAD_F00D;
    rd_req[1] = 1'b1; rd_addr[1] = 9'h50;
    tick(1);
    wb_valid = '0;
    rd_req = '0;
    #1 reset = 1'b1;
    #1;
    chk("midreset_rd_valid", rd_valid, 0);
    chk("midreset_rd_busy", rd_busy, 0);
    chk("midreset_overflow", wb_overflow, 0);
    chk("midreset_rd_data", rd_data, 0);
    tick(2);
    reset = 1'b0;
    tick(2);
    rd_req[0] = 1'b1; rd_addr[0] = 9'h05;
    push(0, 32'hDEAD_BEEF, cyc + 5);
    tick(1);
    rd_req = '0;
    tick(8);

    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
